// File: rtl/fos_decimate_acc.sv
// Integrate-and-dump decimator: averages 2^LOG2_N filter samples
// into a single-entry valid/ready register with overrun tracking.
module fos_decimate_acc #(
  parameter int LOG2_N = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] y_in,
  input  logic        restart,
  output logic [31:0] dec_out,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic        ovf,
  output logic [15:0] drop_cnt,
  input  logic        clr_ovf
);

  localparam int AW = 32 + LOG2_N;
  localparam logic [LOG2_N-1:0] CMAX = '1;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shf;
  logic [LOG2_N-1:0]    cnt;
  logic                 close;
  logic                 overrun;
  logic                 take;

  assign sum     = acc + {{LOG2_N{y_in[31]}}, y_in};
  // arithmetic shift floors toward minus infinity; always fits 32 bits
  assign shf     = sum >>> LOG2_N;
  assign close   = en && !restart && (cnt == CMAX);
  assign take    = dec_valid && dec_ready;
  assign overrun = close && dec_valid && !dec_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (restart || close) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= sum;
      cnt <= cnt + LOG2_N'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_out   <= '0;
      dec_valid <= 1'b0;
    end else if (close) begin
      dec_out   <= shf[31:0];
      dec_valid <= 1'b1;
    end else if (take) begin
      dec_valid <= 1'b0;
    end
  end

  // an overrun in the same cycle as clr_ovf wins and restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (overrun) begin
      ovf <= 1'b1;
      if (clr_ovf)
        drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fos_decimate_acc.sv
// Randomized and directed bench for fos_decimate_acc against a
// window-queue average model.
module tb_fos_decimate_acc;

  localparam int LOG2_N = 2;
  localparam int N = 1 << LOG2_N;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] y_in;
  logic        restart;
  logic [31:0] dec_out;
  logic        dec_valid;
  logic        dec_ready;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;

  longint      win[$];
  logic [31:0] m_out;
  bit          m_v;
  bit          m_ovf;
  int          m_drop;

  fos_decimate_acc #(.LOG2_N(LOG2_N)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .y_in(y_in),
    .restart(restart),
    .dec_out(dec_out),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .ovf(ovf),
    .drop_cnt(drop_cnt),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    win.delete();
    m_out  = '0;
    m_v    = 0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 64'(dec_valid), 64'(m_v));
    chk({tag, ".out"}, 64'(dec_out), 64'(m_out));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic cyc(input string tag, input bit e, input logic [31:0] y,
                     input bit rs, input bit rdy, input bit cl);
    bit     closed;
    longint s;
    longint q;
    en = e; y_in = y; restart = rs; dec_ready = rdy; clr_ovf = cl;
    @(posedge clk);
    closed = 0;
    q = 0;
    if (rs) win.delete();
    else if (e) begin
      win.push_back(longint'($signed(y)));
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        q = s / N;
        if ((s % N) != 0 && s < 0) q -= 1;
        closed = 1;
        win.delete();
      end
    end
    if (cl) begin
      m_ovf = 0;
      m_drop = 0;
    end
    if (closed) begin
      if (m_v && !rdy) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      m_out = q[31:0];
      m_v = 1;
    end else if (m_v && rdy) m_v = 0;
    #1;
    chk_all(tag);
  endtask

  task automatic feed(input string tag, input logic [31:0] y,
                      input bit rdy);
    cyc(tag, 1, y, 0, rdy, 0);
  endtask

  initial begin
    reset = 1'b0;
    en = 0; y_in = '0; restart = 0; dec_ready = 0; clr_ovf = 0;
    m_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    reset = 1'b1;

    feed("avg", 1, 1); feed("avg", 2, 1);
    feed("avg", 3, 1); feed("avg", 6, 1);
    chk("avg3", 64'(dec_out), 64'd3);
    cyc("avg_hold", 0, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) feed("neg", 32'hFFFFFFFF, 1);
    feed("neg", 32'hFFFFFFFE, 1);
    chk("neg_floor", 64'(dec_out), 64'h0FFFFFFFE);
    for (int i = 0; i < 4; i++) feed("max", 32'h7FFFFFFF, 1);
    chk("max", 64'(dec_out), 64'h07FFFFFFF);
    for (int i = 0; i < 4; i++) feed("min", 32'h80000000, 1);
    chk("min", 64'(dec_out), 64'h080000000);

    feed("gap", 4, 1); feed("gap", 4, 1);
    for (int i = 0; i < 3; i++) cyc("gap", 0, 32'd99, 0, 1, 0);
    feed("gap", 4, 1); feed("gap", 4, 1);
    chk("gap4", 64'(dec_out), 64'd4);

    feed("rst", 100, 1); feed("rst", 100, 1);
    cyc("rst", 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) feed("rst", 8, 1);
    chk("restart8", 64'(dec_out), 64'd8);
    feed("rsame", 8, 1);
    cyc("rsame", 1, 32'd1000, 1, 1, 0);
    for (int i = 0; i < 4; i++) feed("rsame", 8, 1);
    chk("rsame8", 64'(dec_out), 64'd8);

    cyc("idle", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) feed("ovr", 5, 0);
    chk("ovr5", 64'(dec_out), 64'd5);
    for (int i = 0; i < 4; i++) feed("ovr", 9, 0);
    chk("ovr9", 64'(dec_out), 64'd9);
    chk("ovr_flag", 64'(ovf), 64'd1);
    chk("ovr_cnt", 64'(drop_cnt), 64'd1);
    cyc("take", 0, 0, 0, 1, 0);
    chk("take_v", 64'(dec_valid), 64'd0);
    chk("take_ovf", 64'(ovf), 64'd1);
    cyc("clr", 0, 0, 0, 0, 1);
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_cnt", 64'(drop_cnt), 64'd0);

    for (int i = 0; i < 4; i++) feed("sim", 7, 0);
    for (int i = 0; i < 3; i++) feed("sim", 11, 0);
    feed("sim", 11, 1);
    chk("sim_v", 64'(dec_valid), 64'd1);
    chk("sim_out", 64'(dec_out), 64'd11);
    chk("sim_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 3; i++) feed("clrov", 20, 0);
    cyc("clrov", 1, 32'd20, 0, 0, 1);
    chk("clrov_ovf", 64'(ovf), 64'd1);
    chk("clrov_cnt", 64'(drop_cnt), 64'd1);

    feed("amid", 50, 0); feed("amid", 50, 0);
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    chk_all("async");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) feed("post", 2, 1);
    chk("post2", 64'(dec_out), 64'd2);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] y;
      y = ($urandom_range(0, 3) == 0) ? $urandom()
                                       : 32'($signed($urandom_range(0, 200)) - 100);
      cyc("rand", $urandom_range(0, 9) < 7, y,
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fos_decimate_acc.md
# fos_decimate_acc

Integrate-and-dump decimator that sits directly downstream of the first-order section filter and consumes its 32-bit signed output stream. It averages every N = 2^LOG2_N accepted samples into one 32-bit result and holds that result in a single-entry valid/ready output register. The filter cannot be stalled, so when the consumer is slow the held result is replaced by the newer one, a sticky overrun flag is set, and the loss is counted.

## Interface
- LOG2_N, 2, log2 of the decimation factor; legal range 1..4, so N = 2..16.
- clk  in  1  rising-edge clock shared with the filter.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- en  in  1  y_in holds a new filter sample this cycle.
- y_in  in  32  signed filter output sample.
- restart  in  1  synchronous; discards the partial window.
- dec_out  out  32  signed averaged result.
- dec_valid  out  1  dec_out holds an untaken result.
- dec_ready  in  1  consumer accepts dec_out this cycle.
- ovf  out  1  sticky flag: an untaken result was overwritten.
- drop_cnt  out  16  count of overwritten results; saturates at 0xFFFF.
- clr_ovf  in  1  synchronous clear of ovf and drop_cnt.

## Operation
- State:
  - signed accumulator acc, 32+LOG2_N bits.
  - sample counter cnt, LOG2_N bits.
  - output register dec_out/dec_valid.
  - ovf and drop_cnt.
- Reset (reset=0): acc=0, cnt=0, dec_out=0, dec_valid=0, ovf=0, drop_cnt=0.
- en=1 with cnt<N-1: acc += sign-extended y_in; cnt += 1.
- en=1 with cnt=N-1, the window closes:
  - sum = acc + y_in at full width.
  - result = sum >>> LOG2_N. This is an arithmetic shift, so it rounds toward minus infinity. The result always fits in 32 bits and no saturation is needed.
  - acc <= 0; cnt <= 0; dec_out <= result; dec_valid <= 1.
- en=0: acc and cnt hold. Gaps in en do not break a window.
- restart=1: acc <= 0 and cnt <= 0. restart has priority over en, so a sample presented in the same cycle is discarded. The output register, ovf and drop_cnt are unaffected.
- Output handshake:
  - A transfer occurs in any cycle where dec_valid=1 and dec_ready=1.
  - If a transfer occurs and no window closes in that cycle, dec_valid <= 0.
- Window close while dec_valid=1 and dec_ready=1: this is a normal transfer. The new result loads and dec_valid stays 1. No overrun is recorded.
- Window close while dec_valid=1 and dec_ready=0: this is an overrun.
  - The new result overwrites dec_out and dec_valid stays 1.
  - ovf <= 1.
  - drop_cnt increments, saturating at 0xFFFF.
- clr_ovf=1: ovf <= 0 and drop_cnt <= 0. If an overrun occurs in the same cycle, the overrun wins: ovf=1 and drop_cnt=1.
- dec_out is stable while dec_valid=1 and dec_ready=0, except when an overrun replaces it.

## Timing
- Latency: if the N-th sample of a window is accepted at edge k, dec_valid=1 and dec_out=result are visible after edge k, i.e. in cycle k+1.
- Throughput: with en=1 continuously, one result every N cycles.
- dec_ready is sampled at the rising edge. There is no combinational path from dec_ready to dec_valid or dec_out.
- Asynchronous reset:
  - Asserting reset mid-window clears the partial sum and any pending output immediately, without waiting for a clock edge.
  - After reset is released, the first accepted sample starts a new window.
- All outputs are registered.

## Test plan
- Basic average, LOG2_N=2, en=1, dec_ready=1: y_in = 1,2,3,6 -> dec_out=3, with dec_valid high for exactly one cycle, in the cycle after the 4th sample.
- Negative rounding: y_in = -1,-1,-1,-2 -> dec_out=-2 (0xFFFFFFFE). Then y_in = 0x7FFFFFFF ×4 -> dec_out=0x7FFFFFFF. Then y_in = 0x80000000 ×4 -> dec_out=0x80000000.
- Gaps and restart:
  - Samples 4,4 then en=0 for 3 cycles, then samples 4,4 -> dec_out=4.
  - Samples 100,100, then restart, then samples 8,8,8,8 -> dec_out=8.
  - restart in the same cycle as en=1 with y_in=1000 -> that sample is ignored.
- Backpressure overrun: dec_ready=0 through two full windows with averages 5 then 9 -> dec_out changes 5 to 9, ovf=1, drop_cnt=1. Then raise dec_ready for one cycle -> dec_valid falls and ovf stays 1. Then clr_ovf -> ovf=0 and drop_cnt=0.
- Simultaneous events:
  - A window closes with dec_valid=1 and dec_ready=1 -> the new result loads, dec_valid stays 1, ovf stays 0.
  - clr_ovf in the same cycle as an overrun -> ovf=1 and drop_cnt=1.
- Reset mid-operation: assert reset after 2 samples of a window while dec_valid=1 -> all outputs are 0 without a clock edge. After release, samples 2,2,2,2 -> dec_out=2, so no residue from the old window.
